// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder: FSM state encoding,
// datapath width constants and a small elaboration-time helper.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sa_state_e;

    // Width of one array element in a weight/input row.
    localparam int ROW_W   = 8;
    // Extra bits a column sum carries on top of SIZE.
    localparam int RES_OFF = 16;

    // Larger of two integers; used to size the shared row/cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa_feeder.sv
// Feeder for a SIZE x SIZE systolic array: loads SIZE weight rows, streams
// SIZE input rows (zero bubbles when the source stalls), waits DRAIN_CYC
// cycles for the array to settle, then captures the column sums.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter int DRAIN_CYC = 2 * SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [SIZE*ROW_W-1:0]        w_row,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic [SIZE*ROW_W-1:0]        x_row,
    output logic [SIZE*ROW_W-1:0]        weight_in,
    output logic                         wload,
    output logic [SIZE*ROW_W-1:0]        in_in,
    input  logic [SIZE*(SIZE+RES_OFF)-1:0] result,
    output logic [SIZE*(SIZE+RES_OFF)-1:0] res_q
);

    localparam int DW    = SIZE * ROW_W;
    localparam int RW    = SIZE * (SIZE + RES_OFF);
    localparam int CNT_W = $clog2(max_int(SIZE, DRAIN_CYC) + 1);

    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    sa_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DW-1:0]      r_weight;
    logic [DW-1:0]      r_in;
    logic [RW-1:0]      r_res;
    logic               r_wload;

    sa_state_e          w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_w_hs;
    logic               w_x_hs;
    logic               w_capture;

    // Handshake readiness and status are pure decodes of the state register.
    assign w_ready   = (r_state == ST_LOAD_W);
    assign x_ready   = (r_state == ST_FEED);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign weight_in = r_weight;
    assign wload     = r_wload;
    assign in_in     = r_in;
    assign res_q     = r_res;

    assign w_w_hs    = w_valid && w_ready;
    assign w_x_hs    = x_valid && x_ready;
    // The column sums are taken on the final drain edge.
    assign w_capture = (r_state == ST_DRAIN) && (r_cnt == LAST_DRAIN);

    // Next-state and shared row/cycle counter logic for the job sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD_W;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                if (w_w_hs) begin
                    if (r_cnt == LAST_ROW) begin
                        w_state_nxt = ST_FEED;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_FEED: begin
                if (w_x_hs) begin
                    if (r_cnt == LAST_ROW) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == LAST_DRAIN) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and the registered rows/strobe/result driven to the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= CNT_ZERO;
            r_weight <= {DW{1'b0}};
            r_in     <= {DW{1'b0}};
            r_res    <= {RW{1'b0}};
            r_wload  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wload <= w_w_hs;
            if (w_w_hs) begin
                r_weight <= w_row;
            end
            // A stalled input source presents a zero bubble to the array.
            r_in <= w_x_hs ? x_row : {DW{1'b0}};
            if (w_capture) begin
                r_res <= result;
            end
        end
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder. Each job is planned as a timeline:
// from the random valid patterns the bench works out at which edges the
// weight and input handshakes land and when the capture edge falls, then
// checks every output after every edge against that timeline.
module tb_sa_feeder;

    localparam int SIZE  = 4;
    localparam int DRAIN = 8;
    localparam int RW    = SIZE + 16;
    localparam int DW    = SIZE * 8;
    localparam int MAXC  = 128;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 w_valid;
    logic                 w_ready;
    logic [DW-1:0]        w_row;
    logic                 x_valid;
    logic                 x_ready;
    logic [DW-1:0]        x_row;
    logic [DW-1:0]        weight_in;
    logic                 wload;
    logic [DW-1:0]        in_in;
    logic [SIZE*RW-1:0]   result;
    logic [SIZE*RW-1:0]   res_q;

    sa_feeder #(.SIZE(SIZE), .DRAIN_CYC(DRAIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_row     (w_row),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_row     (x_row),
        .weight_in (weight_in),
        .wload     (wload),
        .in_in     (in_in),
        .result    (result),
        .res_q     (res_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Rows of the current job and what the DUT should still be holding.
    logic [DW-1:0]      W [SIZE];
    logic [DW-1:0]      X [SIZE];
    logic [DW-1:0]      prev_w;
    logic [SIZE*RW-1:0] prev_res;

    // Per-edge stimulus of the current job (index = edge after start edge 0).
    logic               wv [MAXC];
    logic               xv [MAXC];
    logic               sv [MAXC];
    logic [DW-1:0]      wd [MAXC];
    logic [DW-1:0]      xd [MAXC];
    logic [SIZE*RW-1:0] rd [MAXC];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},      128'(busy),      128'(0));
        chk({tag, ".done"},      128'(done),      128'(0));
        chk({tag, ".w_ready"},   128'(w_ready),   128'(0));
        chk({tag, ".x_ready"},   128'(x_ready),   128'(0));
        chk({tag, ".wload"},     128'(wload),     128'(0));
        chk({tag, ".weight_in"}, 128'(weight_in), 128'(0));
        chk({tag, ".in_in"},     128'(in_in),     128'(0));
        chk({tag, ".res_q"},     128'(res_q),     128'(0));
    endtask

    // One job: pw/px = valid probability (%), abort = reset one edge after
    // the second input row, dense = all valids high (latency check).
    task automatic run_job(input int pw, input int px, input bit abort, input bit dense);
        int wt [SIZE];
        int xt [SIZE];
        int n;
        int dcap;
        int abort_at;
        int done_seen;
        logic [DW-1:0] e_in;
        logic          e_wl;

        for (int k = 0; k < MAXC; k++) begin
            wv[k] = dense || ($urandom_range(99) < pw) || (k >= 40);
            xv[k] = dense || ($urandom_range(99) < px) || (k >= 40);
            sv[k] = 1'($urandom_range(1));
            wd[k] = $urandom;
            xd[k] = $urandom;
            rd[k] = (SIZE*RW)'({$urandom, $urandom, $urandom});
        end
        // Weight handshakes: first SIZE valid edges after the start edge.
        n = 0;
        for (int k = 1; k < MAXC; k++) begin
            if (wv[k] && n < SIZE) begin
                wt[n] = k;
                wd[k] = W[n];
                n++;
            end
        end
        // Input handshakes: first SIZE valid edges after the last weight.
        n = 0;
        for (int k = wt[SIZE-1] + 1; k < MAXC; k++) begin
            if (xv[k] && n < SIZE) begin
                xt[n] = k;
                xd[k] = X[n];
                n++;
            end
        end
        dcap      = xt[SIZE-1] + DRAIN;
        abort_at  = abort ? (xt[1] + 1) : -1;
        done_seen = -1;

        for (int k = 0; k <= dcap + 1; k++) begin
            start   = (k == 0) ? 1'b1 : sv[k];
            w_valid = wv[k];
            w_row   = wd[k];
            x_valid = xv[k];
            x_row   = xd[k];
            result  = rd[k];
            rst_n   = (k == abort_at) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                chk_zero("abort");
                prev_w   = '0;
                prev_res = '0;
                break;
            end
            e_wl = 1'b0;
            e_in = '0;
            for (int i = 0; i < SIZE; i++) begin
                if (wt[i] == k) begin
                    e_wl   = 1'b1;
                    prev_w = W[i];
                end
                if (xt[i] == k) begin
                    e_in = X[i];
                end
            end
            if (k == dcap) begin
                prev_res = rd[dcap];
            end
            if (done === 1'b1 && done_seen < 0) begin
                done_seen = k;
            end
            chk("busy",      128'(busy),      128'(k <= dcap));
            chk("done",      128'(done),      128'(k == dcap));
            chk("w_ready",   128'(w_ready),   128'(k < wt[SIZE-1]));
            chk("x_ready",   128'(x_ready),   128'(k >= wt[SIZE-1] && k < xt[SIZE-1]));
            chk("wload",     128'(wload),     128'(e_wl));
            chk("weight_in", 128'(weight_in), 128'(prev_w));
            chk("in_in",     128'(in_in),     128'(e_in));
            chk("res_q",     128'(res_q),     128'(prev_res));
        end

        // Idle tail: nothing may move, and no stray done pulse.
        start   = 1'b0;
        w_valid = 1'b0;
        x_valid = 1'b0;
        rst_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("idle.busy",  128'(busy),  128'(0));
            chk("idle.done",  128'(done),  128'(0));
            chk("idle.wload", 128'(wload), 128'(0));
            chk("idle.in_in", 128'(in_in), 128'(0));
            chk("idle.res_q", 128'(res_q), 128'(prev_res));
        end
        if (dense) begin
            chk("latency", 128'(done_seen), 128'(2 * SIZE + DRAIN));
        end
    endtask

    task automatic set_rows(input bit directed);
        for (int r = 0; r < SIZE; r++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (directed) begin
                    W[r][8*j +: 8] = 8'(4 * r + j + 1);
                    X[r][8*j +: 8] = 8'(-(4 * r + j + 1));
                end else begin
                    W[r][8*j +: 8] = 8'($urandom_range(255));
                    X[r][8*j +: 8] = 8'($urandom_range(255));
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        w_valid  = 1'b0;
        x_valid  = 1'b0;
        w_row    = '0;
        x_row    = '0;
        result   = '0;
        prev_w   = '0;
        prev_res = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Weights 1..16 and inputs -1..-16, streamed back-to-back.
        set_rows(1'b1);
        run_job(100, 100, 1'b0, 1'b1);

        // Gappy valid streams.
        set_rows(1'b0);
        run_job(40, 40, 1'b0, 1'b0);

        // Abort mid-feed, then a fresh job must complete normally.
        set_rows(1'b1);
        run_job(70, 70, 1'b1, 1'b0);
        set_rows(1'b0);
        run_job(100, 100, 1'b0, 1'b1);

        for (int j = 0; j < 4; j++) begin
            set_rows(1'b0);
            run_job(int'($urandom_range(20, 90)), int'($urandom_range(20, 90)), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
